// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32IM encodings, ALU/immediate enums and decode helpers
package rv32_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;

  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_type_e t);
    case (t)
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return {{20{ins[31]}}, ins[31:20]};
    endcase
  endfunction

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic md);
    alu_op_e r;
    if (md) begin
      case (f3)
        3'd0:    r = ALU_MUL;
        3'd1:    r = ALU_MULH;
        3'd2:    r = ALU_MULHSU;
        3'd3:    r = ALU_MULHU;
        3'd4:    r = ALU_DIV;
        3'd5:    r = ALU_DIVU;
        3'd6:    r = ALU_REM;
        default: r = ALU_REMU;
      endcase
    end else begin
      case (f3)
        F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
        F3_SLL:  r = ALU_SLL;
        F3_SLT:  r = ALU_SLT;
        F3_SLTU: r = ALU_SLTU;
        F3_XOR:  r = ALU_XOR;
        F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
        F3_OR:   r = ALU_OR;
        default: r = ALU_AND;
      endcase
    end
    return r;
  endfunction
endpackage

// File: rtl/rv32_core.sv
// rtl/rv32_core.sv - single-cycle RV32IM core: decode, ALU, mul/div, load/store lanes
module rv32_core import rv32_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  output logic        o_dmem_we
);
  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1, w_rs2, w_imm, w_a, w_b, w_alu, w_load, w_wb_data;
  logic [31:0] w_next_pc, w_pc_plus4, w_pc_imm, w_jalr_tgt;
  logic [1:0]  w_wb_sel;
  logic        w_rf_we, w_mem_we, w_taken;
  imm_type_e   w_imm_type;
  alu_op_e     w_alu_op;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];

  rv32_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_next_pc(w_next_pc), .pc_out(o_pc)
  );

  rv32_regfile u_regfile (
    .clk(clk), .rst_n(rst_n), .i_we(w_rf_we & ~i_stall), .i_rd(i_instr[11:7]),
    .i_wdata(w_wb_data), .i_rs1(i_instr[19:15]), .i_rs2(i_instr[24:20]),
    .o_rs1_data(w_rs1), .o_rs2_data(w_rs2)
  );

  always_comb begin
    case (w_opcode)
      OP_STORE:         w_imm_type = IMM_S;
      OP_BRANCH:        w_imm_type = IMM_B;
      OP_LUI, OP_AUIPC: w_imm_type = IMM_U;
      OP_JAL:           w_imm_type = IMM_J;
      default:          w_imm_type = IMM_I;
    endcase
  end

  assign w_imm       = imm_gen(i_instr, w_imm_type);
  assign w_pc_plus4  = o_pc + 32'd4;
  assign w_pc_imm    = o_pc + w_imm;
  assign w_jalr_tgt  = (w_rs1 + w_imm) & ~32'd1;
  assign o_dmem_addr = w_rs1 + w_imm;

  always_comb begin
    case (w_f3)
      F3_BEQ:  w_taken = (w_rs1 == w_rs2);
      F3_BNE:  w_taken = (w_rs1 != w_rs2);
      F3_BLT:  w_taken = ($signed(w_rs1) < $signed(w_rs2));
      F3_BGE:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
      F3_BLTU: w_taken = (w_rs1 < w_rs2);
      F3_BGEU: w_taken = (w_rs1 >= w_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  // FENCE, SYSTEM and unknown opcodes fall through as NOPs
  always_comb begin
    w_alu_op = ALU_ADD; w_a = w_rs1; w_b = w_imm; w_rf_we = 1'b0;
    w_wb_sel = WB_ALU; w_mem_we = 1'b0; w_next_pc = w_pc_plus4;
    case (w_opcode)
      OP_LUI:    begin w_a = '0; w_rf_we = 1'b1; end
      OP_AUIPC:  begin w_a = o_pc; w_rf_we = 1'b1; end
      OP_JAL:    begin w_rf_we = 1'b1; w_wb_sel = WB_PC4; w_next_pc = w_pc_imm; end
      OP_JALR:   begin w_rf_we = 1'b1; w_wb_sel = WB_PC4; w_next_pc = w_jalr_tgt; end
      OP_BRANCH: if (w_taken) w_next_pc = w_pc_imm;
      OP_LOAD:   begin w_rf_we = 1'b1; w_wb_sel = WB_MEM; end
      OP_STORE:  w_mem_we = 1'b1;
      OP_IMM:    begin
        w_rf_we  = 1'b1;
        w_alu_op = alu_decode(w_f3, (w_f3 == F3_SR) && i_instr[30], 1'b0);
      end
      OP_REG:    begin
        w_rf_we  = 1'b1;
        w_b      = w_rs2;
        w_alu_op = alu_decode(w_f3, i_instr[30], w_f7 == F7_MULDIV);
      end
      default: ;
    endcase
  end

  logic [63:0]        w_mul_ss, w_mul_su, w_mul_uu;
  logic               w_div_zero, w_div_ovf;
  logic [31:0]        w_divs_b, w_divu_b, w_quot_u, w_rem_u;
  logic signed [31:0] w_quot_s, w_rem_s;

  assign w_mul_ss = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};
  assign w_mul_su = {{32{w_a[31]}}, w_a} * {32'b0, w_b};
  assign w_mul_uu = {32'b0, w_a} * {32'b0, w_b};

  // Zero and overflow divisors are swapped for 1 so the dividers never see them;
  // dividing by 1 already yields the required overflow quotient/remainder.
  assign w_div_zero = (w_b == '0);
  assign w_div_ovf  = (w_a == 32'h8000_0000) && (w_b == '1);
  assign w_divs_b   = (w_div_zero || w_div_ovf) ? 32'd1 : w_b;
  assign w_divu_b   = w_div_zero ? 32'd1 : w_b;
  assign w_quot_s   = $signed(w_a) / $signed(w_divs_b);
  assign w_rem_s    = $signed(w_a) % $signed(w_divs_b);
  assign w_quot_u   = w_a / w_divu_b;
  assign w_rem_u    = w_a % w_divu_b;

  always_comb begin
    case (w_alu_op)
      ALU_SUB:    w_alu = w_a - w_b;
      ALU_SLL:    w_alu = w_a << w_b[4:0];
      ALU_SLT:    w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU:   w_alu = {31'b0, w_a < w_b};
      ALU_XOR:    w_alu = w_a ^ w_b;
      ALU_SRL:    w_alu = w_a >> w_b[4:0];
      ALU_SRA:    w_alu = $signed(w_a) >>> w_b[4:0];
      ALU_OR:     w_alu = w_a | w_b;
      ALU_AND:    w_alu = w_a & w_b;
      ALU_MUL:    w_alu = w_mul_uu[31:0];
      ALU_MULH:   w_alu = w_mul_ss[63:32];
      ALU_MULHSU: w_alu = w_mul_su[63:32];
      ALU_MULHU:  w_alu = w_mul_uu[63:32];
      ALU_DIV:    w_alu = w_div_zero ? '1 : w_quot_s;
      ALU_DIVU:   w_alu = w_div_zero ? '1 : w_quot_u;
      ALU_REM:    w_alu = w_div_zero ? w_a : w_rem_s;
      ALU_REMU:   w_alu = w_div_zero ? w_a : w_rem_u;
      default:    w_alu = w_a + w_b;
    endcase
  end

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = 8'(i_dmem_rdata >> {o_dmem_addr[1:0], 3'b000});
  assign w_half = o_dmem_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    case (w_f3)
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load = {{16{w_half[15]}}, w_half};
      F3_BU:   w_load = {24'b0, w_byte};
      F3_HU:   w_load = {16'b0, w_half};
      default: w_load = i_dmem_rdata;
    endcase
  end

  always_comb begin
    o_dmem_be = 4'b1111; o_dmem_wdata = w_rs2;
    case (w_f3)
      F3_B: begin o_dmem_be = 4'b0001 << o_dmem_addr[1:0]; o_dmem_wdata = {4{w_rs2[7:0]}}; end
      F3_H: begin o_dmem_be = o_dmem_addr[1] ? 4'b1100 : 4'b0011; o_dmem_wdata = {2{w_rs2[15:0]}}; end
      default: ;
    endcase
  end

  assign o_dmem_we = w_mem_we & ~i_stall;
  assign w_wb_data = (w_wb_sel == WB_PC4) ? w_pc_plus4 : (w_wb_sel == WB_MEM) ? w_load : w_alu;

  logic w_unused;
  assign w_unused = ^{w_mul_ss[31:0], w_mul_su[31:0]};
endmodule

// File: rtl/rv32_pc.sv
// rtl/rv32_pc.sv - program counter register, held while the SRAM is lent to DMA
module rv32_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic [31:0] i_next_pc,
  output logic [31:0] pc_out
);
  always_ff @(posedge clk) begin
    if (!rst_n)        pc_out <= RESET_PC;
    else if (!i_stall) pc_out <= i_next_pc;
  end
endmodule

// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - 32x32 register file, two async read ports, x0 hardwired to zero
module rv32_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);
  logic [31:0] reg_file [0:31];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (i_we && (i_rd != 5'd0)) begin
      reg_file[i_rd] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : reg_file[i_rs1];
  assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : reg_file[i_rs2];
endmodule

// File: rtl/rv32im_soc_top.sv
// rtl/rv32im_soc_top.sv - RV32IM tile: core, unified word SRAM and DMA-priority port
module rv32im_soc_top import rv32_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_we,
  output logic [31:0] dma_rdata,
  output logic        dma_grant
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   sram [0:MEM_WORDS-1];
  logic [31:0]   w_pc, w_dmem_addr, w_dmem_wdata, w_instr, w_dmem_rdata;
  logic [3:0]    w_dmem_be;
  logic          w_dmem_we, r_irq;
  logic [AW-1:0] w_pc_idx, w_dmem_idx, w_dma_idx;

  assign w_pc_idx     = w_pc[AW+1:2];
  assign w_dmem_idx   = w_dmem_addr[AW+1:2];
  assign w_dma_idx    = dma_addr[AW+1:2];
  assign w_instr      = sram[w_pc_idx];
  assign w_dmem_rdata = sram[w_dmem_idx];
  assign dma_rdata    = sram[w_dma_idx];
  assign dma_grant    = dma_req;

  rv32_core #(.RESET_PC(RESET_PC)) u_core (
    .clk(clk), .rst_n(rst_n), .i_stall(dma_req), .i_instr(w_instr),
    .i_dmem_rdata(w_dmem_rdata), .o_pc(w_pc), .o_dmem_addr(w_dmem_addr),
    .o_dmem_wdata(w_dmem_wdata), .o_dmem_be(w_dmem_be), .o_dmem_we(w_dmem_we)
  );

  // No reset on the array: software is preloaded while rst_n is low
  always_ff @(posedge clk) begin
    if (dma_req) begin
      if (dma_we) sram[w_dma_idx] <= dma_wdata;
    end else if (rst_n && w_dmem_we) begin
      for (int b = 0; b < 4; b++)
        if (w_dmem_be[b]) sram[w_dmem_idx][8*b +: 8] <= w_dmem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= irq;
  end

  logic w_unused;
  assign w_unused = ^{r_irq, w_pc[31:AW+2], w_pc[1:0], w_dmem_addr[31:AW+2],
                      w_dmem_addr[1:0], dma_addr[31:AW+2], dma_addr[1:0]};
endmodule

// File: tb/tb_rv32im_soc_top.sv
// tb/tb_rv32im_soc_top.sv - directed program bench for rv32im_soc_top
module tb_rv32im_soc_top;
  localparam int OPI = 7'b0010011, LD = 7'b0000011, LUI = 7'b0110111;

  logic        clk = 1'b0, rst_n = 1'b0, irq = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
  logic        dma_grant;
  int          n_checks = 0, n_pass = 0;
  logic [31:0] prog [0:33];
  logic [31:0] exp_reg [0:31];

  rv32im_soc_top #(.RESET_PC(32'h0), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_we(dma_we), .dma_rdata(dma_rdata), .dma_grant(dma_grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  initial begin
    prog = '{
      enc_i(5, 0, 0, 1, OPI),      enc_i(10, 0, 0, 2, OPI),     enc_r(0, 2, 1, 0, 3),
      enc_r(32, 2, 1, 0, 4),       enc_r(0, 2, 1, 7, 5),        enc_r(0, 2, 1, 6, 6),
      enc_r(0, 2, 1, 4, 7),        enc_r(0, 2, 1, 2, 8),        enc_r(0, 2, 1, 3, 9),
      enc_i(3, 1, 1, 10, OPI),     enc_i(1, 2, 5, 11, OPI),     enc_u(32'h12345, 12, LUI),
      enc_s(32'h400, 3, 0, 2),     enc_i(32'h400, 0, 2, 13, LD), enc_b(8, 13, 3, 0),
      enc_i(1, 0, 0, 14, OPI),     enc_i(32'h42, 0, 0, 15, OPI), enc_j(8, 16),
      enc_i(1, 0, 0, 17, OPI),     enc_i(32'h55, 0, 0, 18, OPI), enc_r(1, 2, 1, 0, 19),
      enc_r(1, 1, 2, 4, 20),       enc_r(1, 1, 2, 6, 21),       enc_r(1, 0, 1, 4, 22),
      enc_r(1, 0, 1, 6, 23),       enc_u(32'h80000, 24, LUI),   enc_i(-1, 0, 0, 25, OPI),
      enc_r(1, 25, 24, 4, 26),     enc_r(1, 25, 24, 6, 27),     enc_i(32'h404, 24, 5, 28, OPI),
      enc_s(32'h405, 25, 0, 0),    enc_i(32'h405, 0, 4, 29, LD), enc_i(32'h405, 0, 0, 30, LD),
      enc_j(0, 0)
    };
    exp_reg = '{
      32'h0, 32'd5, 32'd10, 32'd15, 32'hFFFF_FFFB, 32'h0, 32'd15, 32'd15,
      32'd1, 32'd1, 32'd40, 32'd5, 32'h1234_5000, 32'd15, 32'h0, 32'h42,
      32'h48, 32'h0, 32'h55, 32'd50, 32'd2, 32'h0, 32'hFFFF_FFFF, 32'd5,
      32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hF800_0000, 32'hFF, 32'hFFFF_FFFF, 32'h0
    };
    for (int i = 0; i < 1024; i++) dut.sram[i] = 32'h0;
    for (int i = 0; i < 34; i++) dut.sram[i] = prog[i];

    tick(2);
    check_eq("reset_pc", dut.u_core.u_pc.pc_out, 32'h0);
    check_eq("reset_x1", dut.u_core.u_regfile.reg_file[1], 32'h0);
    dma_req = 1'b1; dma_addr = 32'h4; #1;
    check_eq("grant_in_reset", {31'b0, dma_grant}, 32'h1);
    check_eq("dma_rdata_in_reset", dma_rdata, 32'h00A0_0113);
    tick(1);
    dma_req = 1'b0;

    rst_n = 1'b1;
    tick(1);
    check_eq("first_retire_x1", dut.u_core.u_regfile.reg_file[1], 32'd5);
    check_eq("first_retire_pc", dut.u_core.u_pc.pc_out, 32'h4);
    tick(9);
    check_eq("pc_before_dma", dut.u_core.u_pc.pc_out, 32'h28);

    for (int k = 0; k < 3; k++) begin
      dma_req = 1'b1; dma_we = 1'b1;
      dma_addr = 32'h800 + 32'(4 * k); dma_wdata = 32'hA5A5_0000 + 32'(k);
      tick(1);
      check_eq("dma_stall_pc", dut.u_core.u_pc.pc_out, 32'h28);
    end
    dma_req = 1'b0; dma_we = 1'b0;
    tick(1);
    check_eq("pc_after_dma", dut.u_core.u_pc.pc_out, 32'h2C);

    for (int i = 0; i < 200 && dut.u_core.u_pc.pc_out != 32'h84; i++) tick(1);
    check_eq("prog_end_pc", dut.u_core.u_pc.pc_out, 32'h84);
    tick(2);
    check_eq("self_loop_pc", dut.u_core.u_pc.pc_out, 32'h84);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("x%0d", i), dut.u_core.u_regfile.reg_file[i], exp_reg[i]);
    check_eq("sram_sw", dut.sram[256], 32'd15);
    check_eq("sram_sb", dut.sram[257], 32'h0000_FF00);
    for (int k = 0; k < 3; k++) begin
      dma_addr = 32'h800 + 32'(4 * k); #1;
      check_eq("dma_written", dma_rdata, 32'hA5A5_0000 + 32'(k));
    end

    rst_n = 1'b0;
    tick(1);
    check_eq("midreset_pc", dut.u_core.u_pc.pc_out, 32'h0);
    check_eq("midreset_x3", dut.u_core.u_regfile.reg_file[3], 32'h0);
    check_eq("midreset_sram_kept", dut.sram[256], 32'd15);

    dut.sram[256] = 32'h0;
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check_eq("pc_at_store", dut.u_core.u_pc.pc_out, 32'h30);
    check_eq("x3_before_store", dut.u_core.u_regfile.reg_file[3], 32'd15);
    rst_n = 1'b0;
    tick(1);
    check_eq("store_reset_pc", dut.u_core.u_pc.pc_out, 32'h0);
    check_eq("store_suppressed", dut.sram[256], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
